fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register of the pipelined ARM core; directly upstream of the controller and datapath decode.
- Holds the fetch PC and selects the next PC from the sequential, branch-taken (E) and PC-write (W) sources.
- Runs a req/ready handshake with instruction memory, tolerating wait states.
- Presents InstrD/PCPlus8D/ValidD to decode; honours hazard-unit StallF/StallD/FlushD; reports FetchBusy back to the hazard unit.

Parameters:
RESET_PC, 32'h0000_0000, fetch address loaded on reset
PC_WIDTH, 32, width of all PC/address buses

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (asserted at 0)
StallF  input  1  hold fetch PC (hazard unit)
StallD  input  1  hold IF/ID register
FlushD  input  1  clear IF/ID register to bubble
BranchTakenE  input  1  branch resolved taken in Execute
ALUResultE  input  PC_WIDTH  branch target from Execute
PCSrcW  input  1  instruction in Writeback writes PC
ResultW  input  PC_WIDTH  PC value from Writeback
imem_req  output  1  fetch request valid
imem_addr  output  PC_WIDTH  fetch address (= PCF)
imem_rdata  input  32  instruction word, valid when imem_ready
imem_ready  input  1  memory completes the current request this cycle
PCF  output  PC_WIDTH  current fetch PC
InstrD  output  32  instruction to decode/controller
PCPlus8D  output  PC_WIDTH  address of InstrD + 8
ValidD  output  1  InstrD holds a real instruction
FetchBusy  output  1  fetch cannot complete this cycle (stall request)

Behaviour:
- Reset (reset=0, async): PCF=RESET_PC; state=FETCH; RedirectPC=0; InstrD=0; PCPlus8D=0; ValidD=0. imem_req=0 while reset is asserted and 1 otherwise. A reset mid-DRAIN abandons the drain.
- Redirect target priority: BranchTakenE→ALUResultE, else PCSrcW→ResultW. redirect = BranchTakenE | PCSrcW.
- Address stability: imem_addr=PCF and never changes between request and imem_ready.
- State FETCH:
  - ready=1, redirect=1: PCF←target; fetched word still enters IF/ID (hazard unit flushes it via FlushD).
  - ready=1, redirect=0, StallF=0: PCF←PCF+4 (mod 2^PC_WIDTH).
  - ready=1, redirect=0, StallF=1: PCF held; same address re-requested next cycle.
  - ready=0, redirect=0: PCF held.
  - ready=0, redirect=1: RedirectPC←target; →DRAIN; PCF held.
  - Redirect overrides StallF.
- State DRAIN:
  - imem_req=1, addr=PCF (the old address).
  - Each redirect overwrites RedirectPC; same priority, so the latest redirect wins.
  - ready=1 with no redirect that cycle: response discarded; PCF←RedirectPC; →FETCH.
  - ready=1 with a redirect that cycle: PCF←new target directly.
- IF/ID register, priority FlushD > StallD > load:
  - FlushD: InstrD=0, ValidD=0, PCPlus8D=0.
  - StallD: all held.
  - Otherwise, if state=FETCH & imem_ready: InstrD←imem_rdata, PCPlus8D←PCF+8, ValidD←1.
  - Otherwise a bubble is loaded: InstrD=0, ValidD=0.
- FetchBusy (combinational) = (state=DRAIN) | (state=FETCH & ~imem_ready); 0 during reset.
- Latency: zero-wait memory gives one instruction per cycle; InstrD appears on the edge after the fetch completes.
- Adder arithmetic: PC+4 and PC+8 wrap modulo 2^PC_WIDTH, no overflow flag.

Test Plan:
- Reset release, ready tied 1 → PCF 0,4,8,12 on successive cycles; InstrD follows one cycle later; PCPlus8D = address+8; ValidD=1 from the second cycle.
- Assert reset for 1 cycle mid-stream at PCF=0x20 → outputs clear immediately (async); fetch restarts at RESET_PC; imem_req=0 during reset.
- ready=0 for 3 cycles at PCF=0x10 → PCF and imem_addr held at 0x10; FetchBusy=1; InstrD bubbles (ValidD=0); word delivered when ready rises.
- BranchTakenE=1, ALUResultE=0x100, ready=1 → next PCF=0x100; same cycle FlushD=1 → ValidD=0.
- Redirect during wait: ready=0 at 0x40, PCSrcW=1, ResultW=0x80, then BranchTakenE=1 with 0xC0 one cycle later, ready=1 on the third cycle → imem_addr stays 0x40; response discarded; PCF=0xC0; ValidD never set for 0x40.
- BranchTakenE and PCSrcW together (0x200 vs 0x300) with StallF=1 → PCF=0x200. StallD=1 with FlushD=1 → IF/ID cleared.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage -- instruction-fetch stage and IF/ID pipeline register.
//
// Holds the fetch PC (PCF) and selects the next PC from three sources: the
// sequential PC+4, the branch target from Execute, or a PC write from
// Writeback. It also runs a req/ready handshake with instruction memory and
// tolerates any number of wait states.
//
// Ports
//   clk, reset        clock (rising edge); asynchronous active-low reset
//   StallF            hold the fetch PC (hazard unit)
//   StallD            hold the IF/ID register
//   FlushD            clear the IF/ID register to a bubble (wins over StallD)
//   BranchTakenE      branch resolved taken in Execute; target on ALUResultE
//   PCSrcW            Writeback writes the PC; value on ResultW
//   imem_req          request valid (high whenever reset is released)
//   imem_addr         request address, always equal to PCF
//   imem_rdata        instruction word, valid when imem_ready is high
//   imem_ready        memory completes the current request this cycle
//   PCF               current fetch PC
//   InstrD            instruction presented to decode
//   PCPlus8D          address of InstrD plus 8
//   ValidD            InstrD holds a real instruction
//   FetchBusy         fetch cannot complete this cycle (stall request)
//
// Handshake: a request is outstanding whenever imem_req is high. The address
// is held stable from the cycle the request starts until the cycle
// imem_ready is seen high; that cycle completes the request, and the next
// cycle starts a new request at the (possibly updated) PCF.
module fetch_stage #(
   parameter int                  PC_WIDTH = 32,
   parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                StallF,
   input  logic                StallD,
   input  logic                FlushD,
   input  logic                BranchTakenE,
   input  logic [PC_WIDTH-1:0] ALUResultE,
   input  logic                PCSrcW,
   input  logic [PC_WIDTH-1:0] ResultW,
   output logic                imem_req,
   output logic [PC_WIDTH-1:0] imem_addr,
   input  logic [31:0]         imem_rdata,
   input  logic                imem_ready,
   output logic [PC_WIDTH-1:0] PCF,
   output logic [31:0]         InstrD,
   output logic [PC_WIDTH-1:0] PCPlus8D,
   output logic                ValidD,
   output logic                FetchBusy
);

   // FETCH: normal operation. DRAIN: a redirect arrived while a request was
   // still outstanding; we wait for that stale response, discard it, then
   // jump to the saved redirect target.
   typedef enum logic {
      FETCH = 1'b0,
      DRAIN = 1'b1
   } state_t;

   state_t              state, state_next;
   logic [PC_WIDTH-1:0] pcf_next;
   logic [PC_WIDTH-1:0] redirect_pc, redirect_pc_next;
   logic [PC_WIDTH-1:0] target;
   logic                redirect;
   logic                load_d;

   // Branch from Execute is younger than the Writeback PC write, so it wins.
   assign redirect = BranchTakenE | PCSrcW;
   assign target   = BranchTakenE ? ALUResultE : ResultW;

   always_comb begin
      state_next       = state;
      pcf_next         = PCF;
      redirect_pc_next = redirect_pc;
      case (state)
         FETCH: begin
            if (imem_ready) begin
               // Redirect overrides StallF.
               if (redirect)     pcf_next = target;
               else if (!StallF) pcf_next = PCF + PC_WIDTH'(4);
            end else if (redirect) begin
               // Request still outstanding: PCF (and so imem_addr) must not
               // move, so park the target until the response arrives.
               redirect_pc_next = target;
               state_next       = DRAIN;
            end
         end
         DRAIN: begin
            if (redirect) redirect_pc_next = target;  // latest redirect wins
            if (imem_ready) begin
               pcf_next   = redirect ? target : redirect_pc;
               state_next = FETCH;
            end
         end
         default: state_next = FETCH;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= FETCH;
         PCF         <= RESET_PC;
         redirect_pc <= '0;
      end else begin
         state       <= state_next;
         PCF         <= pcf_next;
         redirect_pc <= redirect_pc_next;
      end
   end

   // Responses arriving in DRAIN belong to an abandoned address and never
   // reach decode.
   assign load_d = (state == FETCH) && imem_ready;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         InstrD   <= '0;
         PCPlus8D <= '0;
         ValidD   <= 1'b0;
      end else if (FlushD) begin
         InstrD   <= '0;
         PCPlus8D <= '0;
         ValidD   <= 1'b0;
      end else if (StallD) begin
         InstrD   <= InstrD;
         PCPlus8D <= PCPlus8D;
         ValidD   <= ValidD;
      end else if (load_d) begin
         InstrD   <= imem_rdata;
         PCPlus8D <= PCF + PC_WIDTH'(8);
         ValidD   <= 1'b1;
      end else begin
         // Bubble; PCPlus8D is meaningless while ValidD is low and is held.
         InstrD   <= '0;
         ValidD   <= 1'b0;
      end
   end

   assign imem_req  = reset;
   assign imem_addr = PCF;
   assign FetchBusy = reset && ((state == DRAIN) || !imem_ready);

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage -- directed and randomized bench for fetch_stage.
//
// The reference model tracks the architectural view only: the PC, whether a
// stale response is still owed to us (with the address we go to afterwards),
// and the contents of decode. Memory contents are a pure function of address.
module tb_fetch_stage;

   localparam int PW = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic          StallF, StallD, FlushD;
   logic          BranchTakenE, PCSrcW;
   logic [PW-1:0] ALUResultE, ResultW;
   logic          imem_req;
   logic [PW-1:0] imem_addr;
   logic [31:0]   imem_rdata;
   logic          imem_ready;
   logic [PW-1:0] PCF;
   logic [31:0]   InstrD;
   logic [PW-1:0] PCPlus8D;
   logic          ValidD;
   logic          FetchBusy;

   fetch_stage #(.PC_WIDTH(PW), .RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .reset(reset),
      .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
      .BranchTakenE(BranchTakenE), .ALUResultE(ALUResultE),
      .PCSrcW(PCSrcW), .ResultW(ResultW),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_rdata(imem_rdata), .imem_ready(imem_ready),
      .PCF(PCF), .InstrD(InstrD), .PCPlus8D(PCPlus8D),
      .ValidD(ValidD), .FetchBusy(FetchBusy)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- memory ----------------
   logic [31:0] salt;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0] ^ 16'hE3A0, ~a[31:16]} ^ salt;
   endfunction

   always_comb imem_rdata = mem_word(imem_addr);

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // ---------------- reference model ----------------
   logic [31:0] m_pc;
   bit          m_owed;      // a stale response must be swallowed first
   logic [31:0] m_after;     // where fetch resumes after the stale response
   logic [31:0] m_instr;
   logic [31:0] m_pcp8;
   bit          m_valid;

   task automatic model_reset();
      m_pc = 32'h0; m_owed = 0; m_after = 32'h0;
      m_instr = 32'h0; m_pcp8 = 32'h0; m_valid = 0;
   endtask

   // Advance the model by one clock using the inputs present at the edge.
   task automatic model_step();
      logic [31:0] tgt;
      bit          redir, deliver;
      logic [31:0] old_pc;
      redir   = BranchTakenE || PCSrcW;
      tgt     = BranchTakenE ? ALUResultE : ResultW;
      old_pc  = m_pc;
      deliver = imem_ready && !m_owed;

      if (m_owed) begin
         if (redir) m_after = tgt;
         if (imem_ready) begin
            m_owed = 0;
            m_pc   = m_after;
         end
      end else if (imem_ready) begin
         if (redir)        m_pc = tgt;
         else if (!StallF) m_pc = old_pc + 32'd4;
      end else if (redir) begin
         m_owed  = 1;
         m_after = tgt;
      end

      if (FlushD) begin
         m_instr = 0; m_pcp8 = 0; m_valid = 0;
      end else if (!StallD) begin
         if (deliver) begin
            m_instr = mem_word(old_pc);
            m_pcp8  = old_pc + 32'd8;
            m_valid = 1;
         end else begin
            m_instr = 0;
            m_valid = 0;
         end
      end
   endtask

   // ---------------- driver ----------------
   task automatic drive(input bit rdy, input bit bt, input logic [31:0] alu,
                        input bit pcs, input logic [31:0] resw,
                        input bit sf, input bit sd, input bit fl);
      imem_ready = rdy; BranchTakenE = bt; ALUResultE = alu;
      PCSrcW = pcs; ResultW = resw; StallF = sf; StallD = sd; FlushD = fl;
   endtask

   // Called at a falling edge with inputs already driven.
   task automatic cycle();
      #1;
      chk("imem_req", {31'b0, imem_req}, 32'd1);
      chk("imem_addr", imem_addr, m_pc);
      chk("FetchBusy", {31'b0, FetchBusy}, {31'b0, (m_owed || !imem_ready)});
      @(posedge clk);
      model_step();
      #1;
      chk("PCF", PCF, m_pc);
      chk("ValidD", {31'b0, ValidD}, {31'b0, m_valid});
      chk("InstrD", InstrD, m_instr);
      if (m_valid) chk("PCPlus8D", PCPlus8D, m_pcp8);
      @(negedge clk);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      salt = $urandom;
      reset = 1'b0;
      drive(1, 0, 0, 0, 0, 0, 0, 0);
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_PCF", PCF, 32'h0);
      chk("rst_ValidD", {31'b0, ValidD}, 32'd0);
      chk("rst_InstrD", InstrD, 32'h0);
      chk("rst_PCPlus8D", PCPlus8D, 32'h0);
      chk("rst_imem_req", {31'b0, imem_req}, 32'd0);
      chk("rst_FetchBusy", {31'b0, FetchBusy}, 32'd0);
      @(negedge clk);
      reset = 1'b1;

      // Zero-wait streaming from reset.
      for (int i = 0; i < 8; i++) cycle();
      chk("stream_PCF", PCF, 32'h20);
      chk("stream_PCPlus8D", PCPlus8D, 32'h24);

      // Asynchronous reset mid-stream, away from any clock edge.
      #2 reset = 1'b0;
      #1;
      chk("arst_PCF", PCF, 32'h0);
      chk("arst_ValidD", {31'b0, ValidD}, 32'd0);
      chk("arst_InstrD", InstrD, 32'h0);
      chk("arst_imem_req", {31'b0, imem_req}, 32'd0);
      @(posedge clk);
      #1;
      chk("arst_hold_PCF", PCF, 32'h0);
      @(negedge clk);
      reset = 1'b1;
      model_reset();

      // Stream to 0x10, then three wait states.
      for (int i = 0; i < 4; i++) cycle();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk("wait_PCF", PCF, 32'h10);
         chk("wait_busy", {31'b0, FetchBusy}, 32'd1);
      end
      drive(1, 0, 0, 0, 0, 0, 0, 0);
      cycle();
      chk("wait_deliver", InstrD, mem_word(32'h10));

      // Taken branch with same-cycle flush.
      drive(1, 1, 32'h100, 0, 0, 0, 0, 1);
      cycle();
      chk("br_PCF", PCF, 32'h100);
      chk("br_flush_ValidD", {31'b0, ValidD}, 32'd0);

      // Redirects while the request at 0x40 is waiting.
      drive(1, 1, 32'h40, 0, 0, 0, 0, 0);
      cycle();
      drive(0, 0, 0, 1, 32'h80, 0, 0, 0);
      cycle();
      drive(0, 1, 32'hC0, 0, 0, 0, 0, 0);
      cycle();
      chk("drain_hold_addr", imem_addr, 32'h40);
      drive(1, 0, 0, 0, 0, 0, 0, 0);
      cycle();
      chk("drain_PCF", PCF, 32'hC0);
      chk("drain_discard", {31'b0, ValidD}, 32'd0);
      cycle();
      chk("drain_next", InstrD, mem_word(32'hC0));

      // Both redirects together with StallF; then StallD with FlushD.
      drive(1, 1, 32'h200, 1, 32'h300, 1, 0, 0);
      cycle();
      chk("prio_PCF", PCF, 32'h200);
      drive(1, 0, 0, 0, 0, 0, 1, 1);
      cycle();
      chk("flush_stall_ValidD", {31'b0, ValidD}, 32'd0);
      chk("flush_stall_InstrD", InstrD, 32'h0);
      chk("flush_stall_PCPlus8D", PCPlus8D, 32'h0);

      // Randomized traffic against the model.
      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(0, 9) < 7,
               $urandom_range(0, 9) == 0, {$urandom_range(0, 32'h3FFF), 2'b00},
               $urandom_range(0, 9) == 0, {$urandom_range(0, 32'h3FFF), 2'b00},
               $urandom_range(0, 6) == 0, $urandom_range(0, 9) == 0,
               $urandom_range(0, 9) == 0);
         cycle();
      end

      // Wrap of PC+4 / PC+8 at the top of the address space.
      drive(1, 1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0);
      cycle();
      drive(1, 0, 0, 0, 0, 0, 0, 0);
      cycle();
      chk("wrap_PCF", PCF, 32'h0);
      chk("wrap_PCPlus8D", PCPlus8D, 32'h4);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
